// File: rtl/xbus_arb_pkg.sv
// Shared types and defaults for the two-master controller bus arbiter.
package xbus_arb_pkg;

  typedef enum logic {
    ARB_OWN0 = 1'b0,
    ARB_OWN1 = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_HOLD_DEF = 16;
  localparam int ARB_ADDR_W_DEF   = 16;
  localparam int ARB_DATA_W_DEF   = 32;

  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold);
  endfunction

endpackage

// File: rtl/xbus_arb_mux.sv
// Owner-selected 2:1 mux of the masters' {req, we, addr, wdata} onto the bus.
module xbus_arb_mux
  import xbus_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W_DEF,
  parameter int DATA_W = ARB_DATA_W_DEF
) (
  input  arb_state_e        owner_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  always_comb begin
    req_o   = m0_req_i;
    we_o    = m0_we_i;
    addr_o  = m0_addr_i;
    wdata_o = m0_wdata_i;
    case (owner_i)
      ARB_OWN0: begin
        req_o   = m0_req_i;
        we_o    = m0_we_i;
        addr_o  = m0_addr_i;
        wdata_o = m0_wdata_i;
      end
      ARB_OWN1: begin
        req_o   = m1_req_i;
        we_o    = m1_we_i;
        addr_o  = m1_addr_i;
        wdata_o = m1_wdata_i;
      end
      default: begin
        req_o   = m0_req_i;
        we_o    = m0_we_i;
        addr_o  = m0_addr_i;
        wdata_o = m0_wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/xbus_arb.sv
// Two-master bus arbiter with parked registered grant, lock bursts bounded by MAX_HOLD.
// Define ARB_FIXED_PRIO_EN to give master 0 strict priority instead of round-robin.
module xbus_arb
  import xbus_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W_DEF,
  parameter int DATA_W   = ARB_DATA_W_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m_rdata,
  output logic              bus_sel,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              owner
);

  localparam int               HOLD_W   = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              req_own_s, req_oth_s, lock_own_s, hold_top_s, switch_s;

  xbus_arb_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .owner_i   (state_q),
    .m0_req_i  (m0_req),
    .m0_we_i   (m0_we),
    .m0_addr_i (m0_addr),
    .m0_wdata_i(m0_wdata),
    .m1_req_i  (m1_req),
    .m1_we_i   (m1_we),
    .m1_addr_i (m1_addr),
    .m1_wdata_i(m1_wdata),
    .req_o     (req_own_s),
    .we_o      (bus_we),
    .addr_o    (bus_addr),
    .wdata_o   (bus_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_OWN0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    switch_s   = 1'b0;
    req_oth_s  = m1_req;
    lock_own_s = m0_lock;
    hold_top_s = (hold_q == HOLD_TOP);
    case (state_q)
      ARB_OWN0: begin
        req_oth_s  = m1_req;
        lock_own_s = m0_lock;
      end
      ARB_OWN1: begin
        req_oth_s  = m0_req;
        lock_own_s = m1_lock;
      end
      default: begin
        req_oth_s  = m1_req;
        lock_own_s = m0_lock;
      end
    endcase
`ifdef ARB_FIXED_PRIO_EN
    // Master 0 never yields while it requests; master 1 yields unless a bounded lock holds it.
    case (state_q)
      ARB_OWN0: switch_s = m1_req & ~m0_req;
      ARB_OWN1: switch_s = m0_req & (~m1_req | ~lock_own_s | hold_top_s);
      default:  switch_s = 1'b0;
    endcase
`else
    switch_s = req_oth_s & (~req_own_s | ~lock_own_s | hold_top_s);
`endif
    if (switch_s) begin
      state_d = (state_q == ARB_OWN0) ? ARB_OWN1 : ARB_OWN0;
      hold_d  = '0;
    end else if (!req_oth_s) begin
      hold_d = '0;
    end else if (req_own_s && !hold_top_s) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  assign owner   = state_q;
  assign m0_gnt  = (state_q == ARB_OWN0);
  assign m1_gnt  = (state_q == ARB_OWN1);
  assign bus_sel = req_own_s;
  assign m_rdata = bus_rdata;

endmodule

// File: tb/tb_xbus_arb.sv
// Self-checking bench for xbus_arb: vector table, burst/reset sequences, random vs reference model.
module tb_xbus_arb;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, bus_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, bus_wdata, bus_rdata, m_rdata;
  logic          m0_gnt, m1_gnt, bus_sel, bus_we, owner;

  int n_cmp = 0;
  int n_bad = 0;
  int m1_commits = 0;

  typedef struct {
    logic          rst;
    logic          r0, l0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, l1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [DW-1:0] rd;
    logic          e_own, e_g0, e_g1, e_sel, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  // reference model state: current owner and contended accesses done in its tenure
  int       mdl_own, mdl_streak;
  logic     rq[2], lk[2], wv[2];
  logic [AW-1:0] av[2];
  logic [DW-1:0] dv[2];
  logic [DW-1:0] rdv;

  xbus_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m_rdata(m_rdata), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus_sel && bus_we && m1_gnt) m1_commits++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_row(input vec_t v);
    rst = v.rst;
    m0_req = v.r0; m0_lock = v.l0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_lock = v.l1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    bus_rdata = v.rd;
  endtask

  task automatic drive_model_inputs();
    m0_req = rq[0]; m0_lock = lk[0]; m0_we = wv[0]; m0_addr = av[0]; m0_wdata = dv[0];
    m1_req = rq[1]; m1_lock = lk[1]; m1_we = wv[1]; m1_addr = av[1]; m1_wdata = dv[1];
    bus_rdata = rdv;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
    bus_rdata = 8'h00;

    // rst, {m0 r l w a d}, {m1 r l w a d}, rd, {own g0 g1 sel we addr wd rd}
    tbl.push_back('{1'b1, 1'b1,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h00,
                    1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,8'h00,8'h00});
    tbl.push_back('{1'b0, 1'b1,1'b0,1'b1,8'h10,8'hAB, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h00,
                    1'b0,1'b1,1'b0,1'b1,1'b1,8'h10,8'hAB,8'h00});
    tbl.push_back('{1'b0, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 8'h55,
                    1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,8'h55});
    tbl.push_back('{1'b0, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 8'h55,
                    1'b1,1'b0,1'b1,1'b1,1'b0,8'h20,8'h00,8'h55});
    for (int i = 0; i < 2; i++)
      tbl.push_back('{1'b0, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h20,8'h00, 8'h00,
                      1'b1,1'b0,1'b1,1'b0,1'b0,8'h20,8'h00,8'h00});
    tbl.push_back('{1'b0, 1'b1,1'b0,1'b0,8'h30,8'h00, 1'b0,1'b0,1'b0,8'h20,8'h00, 8'h00,
                    1'b1,1'b0,1'b1,1'b0,1'b0,8'h20,8'h00,8'h00});
`ifndef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        tbl.push_back('{1'b0, 1'b1,1'b0,1'b1,8'h30,8'h11, 1'b1,1'b0,1'b1,8'h40,8'h22, 8'h3C,
                        1'b0,1'b1,1'b0,1'b1,1'b1,8'h30,8'h11,8'h3C});
      else
        tbl.push_back('{1'b0, 1'b1,1'b0,1'b1,8'h30,8'h11, 1'b1,1'b0,1'b1,8'h40,8'h22, 8'h3C,
                        1'b1,1'b0,1'b1,1'b1,1'b1,8'h40,8'h22,8'h3C});
    end
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive_row(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_owner", i), {31'b0, owner}, {31'b0, tbl[i].e_own});
      chk($sformatf("vec%0d_m0_gnt", i), {31'b0, m0_gnt}, {31'b0, tbl[i].e_g0});
      chk($sformatf("vec%0d_m1_gnt", i), {31'b0, m1_gnt}, {31'b0, tbl[i].e_g1});
      chk($sformatf("vec%0d_bus_sel", i), {31'b0, bus_sel}, {31'b0, tbl[i].e_sel});
      chk($sformatf("vec%0d_bus_we", i), {31'b0, bus_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("vec%0d_bus_addr", i), {24'b0, bus_addr}, {24'b0, tbl[i].e_addr});
      chk($sformatf("vec%0d_bus_wdata", i), {24'b0, bus_wdata}, {24'b0, tbl[i].e_wd});
      chk($sformatf("vec%0d_m_rdata", i), {24'b0, m_rdata}, {24'b0, tbl[i].e_rd});
    end

`ifndef ARB_FIXED_PRIO_EN
    // locked m0 burst vs waiting m1: MH m0 accesses, one m1, repeat; reset lands on 2nd m1 cycle
    @(posedge clk); #1;
    m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b1; m0_addr = 8'h50; m0_wdata = 8'h05;
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b1; m1_addr = 8'h60; m1_wdata = 8'h06;
    base = m1_commits;
    for (int c = 0; c < 2 * (MH + 1); c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk($sformatf("lock_c%0d_owner", c), {31'b0, owner}, (c % (MH + 1) == MH) ? 32'd1 : 32'd0);
      chk($sformatf("lock_c%0d_addr", c), {24'b0, bus_addr},
          (c % (MH + 1) == MH) ? 32'h60 : 32'h50);
    end
    chk("lock_m1_commit_once", m1_commits - base, 32'd1);
    chk("rstmid_m1_gnt_before", {31'b0, m1_gnt}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_owner", {31'b0, owner}, 32'd0);
    chk("rstmid_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("rstmid_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    chk("rstmid_bus_addr", {24'b0, bus_addr}, 32'h50);
    @(posedge clk); #1;
    chk("rstmid_no_m1_commit", m1_commits - base, 32'd1);
    rst = 1'b0;
`else
    // strict priority: m1 starves while m0 requests, gets bus the edge after m0 drops
    @(posedge clk); #1;
    m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = 8'h70;
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 8'h71;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("prio_c%0d_m1_gnt", c), {31'b0, m1_gnt}, 32'd0);
      chk($sformatf("prio_c%0d_addr", c), {24'b0, bus_addr}, 32'h70);
      @(posedge clk); #1;
    end
    m0_req = 1'b0;
    @(negedge clk);
    chk("prio_drop_same_cycle", {31'b0, m1_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("prio_drop_next_edge", {31'b0, m1_gnt}, 32'd1);
    chk("prio_drop_bus_addr", {24'b0, bus_addr}, 32'h71);
`endif

    // randomized traffic against the reference model
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rq[k] = 1'b0; lk[k] = 1'b0; wv[k] = 1'b0; av[k] = '0; dv[k] = '0;
    end
    rdv = '0;
    drive_model_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_own = 0;
    mdl_streak = 0;
    for (int i = 0; i < 400; i++) begin
      logic done[2];
      int   oth;
      bit   sw;
      for (int k = 0; k < 2; k++) begin
        done[k] = 1'b0;
        if (!rq[k] || (i > 0 && 1'b0)) begin
          if ($urandom_range(0, 99) < 55) begin
            rq[k] = 1'b1; wv[k] = 1'($urandom); av[k] = AW'($urandom); dv[k] = DW'($urandom);
          end
        end
        lk[k] = ($urandom_range(0, 99) < 50);
      end
      rdv = DW'($urandom);
      drive_model_inputs();
      @(negedge clk);
      chk("rnd_owner", {31'b0, owner}, mdl_own);
      chk("rnd_m0_gnt", {31'b0, m0_gnt}, (mdl_own == 0) ? 32'd1 : 32'd0);
      chk("rnd_m1_gnt", {31'b0, m1_gnt}, (mdl_own == 1) ? 32'd1 : 32'd0);
      chk("rnd_bus_sel", {31'b0, bus_sel}, {31'b0, rq[mdl_own]});
      chk("rnd_bus_we", {31'b0, bus_we}, {31'b0, wv[mdl_own]});
      chk("rnd_bus_addr", {24'b0, bus_addr}, {24'b0, av[mdl_own]});
      chk("rnd_bus_wdata", {24'b0, bus_wdata}, {24'b0, dv[mdl_own]});
      chk("rnd_m_rdata", {24'b0, m_rdata}, {24'b0, rdv});
      @(posedge clk);
      oth = 1 - mdl_own;
      done[mdl_own] = rq[mdl_own];
`ifdef ARB_FIXED_PRIO_EN
      if (mdl_own == 0) sw = rq[1] && !rq[0];
      else sw = rq[0] && (!rq[1] || !lk[1] || mdl_streak == MH - 1);
`else
      sw = rq[oth] && (!rq[mdl_own] || !lk[mdl_own] || mdl_streak == MH - 1);
`endif
      if (sw || !rq[oth]) mdl_streak = 0;
      else if (rq[mdl_own] && mdl_streak < MH - 1) mdl_streak = mdl_streak + 1;
      if (sw) mdl_own = oth;
      #1;
      // a finished access may be followed immediately by a fresh one or by idling
      for (int k = 0; k < 2; k++)
        if (done[k]) rq[k] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
